// File: rtl/button_conditioner.sv
// button_conditioner: turns three raw active-low keys (increment, decrement,
// clear) into clean one-cycle command pulses plus debounced level outputs.
// Each key path: 2-flop synchronizer -> counting debouncer -> press FSM.
// Inc/dec keys have optional hold-to-repeat; the clear key has none.
// Conflicting inc+dec holds and a held clear key suppress inc/dec commands.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_increment,
  input  logic btn_decrement,
  input  logic btn_reset,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic clr_pulse,
  output logic inc_held,
  output logic dec_held,
  output logic clr_held
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LIMIT     = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]  DB_ONE       = DB_W'(1);
  localparam logic [RPT_W-1:0] RPT_DELAY_C  = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PERIOD_C = RPT_W'(REPEAT_PERIOD);
  localparam logic [RPT_W-1:0] RPT_ONE      = RPT_W'(1);
  localparam logic [RPT_W-1:0] RPT_SAT      = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } key_state_t;

  // Bit order for all per-key vectors: [0] increment, [1] decrement, [2] clear.
  logic [2:0] raw_key;
  logic [2:0] sync1_reg;
  logic [2:0] sync2_reg;
  logic [2:0] stable_level;   // debounced level, 1 = pressed
  logic [2:0] held_reg;
  logic [1:0] rpt_event;      // press/repeat events from the inc/dec FSMs
  logic       clr_event;

  key_state_t clr_state_reg;
  key_state_t clr_state_next;

  logic inc_pulse_reg;
  logic dec_pulse_reg;
  logic clr_pulse_reg;
  logic inc_pulse_next;
  logic dec_pulse_next;
  logic clr_pulse_next;

  assign raw_key = {btn_reset, btn_decrement, btn_increment};

  // Two-stage synchronizer; released (1) is the safe reset value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg <= 3'b111;
      sync2_reg <= 3'b111;
    end else begin
      sync1_reg <= raw_key;
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;

  generate
    for (gi = 0; gi < 3; gi++) begin : g_debounce
      logic            stable_reg;
      logic [DB_W-1:0] db_cnt_reg;
      logic            sample_pressed;

      assign sample_pressed = ~sync2_reg[gi];

      // Count consecutive disagreeing samples; flip the level once the run is long enough.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          stable_reg <= 1'b0;
          db_cnt_reg <= '0;
        end else if (db_cnt_reg == DB_LIMIT) begin
          stable_reg <= ~stable_reg;
          db_cnt_reg <= '0;
        end else if (sample_pressed != stable_reg) begin
          db_cnt_reg <= db_cnt_reg + DB_ONE;
        end else begin
          db_cnt_reg <= '0;
        end
      end

      assign stable_level[gi] = stable_reg;
    end
  endgenerate

  generate
    for (gi = 0; gi < 2; gi++) begin : g_repeat
      key_state_t       state_reg;
      key_state_t       state_next;
      logic [RPT_W-1:0] rcnt_reg;
      logic [RPT_W-1:0] rcnt_next;
      logic             event_now;

      // Press/repeat FSM state and repeat counter.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_reg <= ST_IDLE;
          rcnt_reg  <= '0;
        end else begin
          state_reg <= state_next;
          rcnt_reg  <= rcnt_next;
        end
      end

      // Counter starts at 1 on entry so an event fires exactly DELAY/PERIOD cycles later.
      always_comb begin
        state_next = state_reg;
        rcnt_next  = rcnt_reg;
        event_now  = 1'b0;
        if (!stable_level[gi]) begin
          state_next = ST_IDLE;
          rcnt_next  = '0;
        end else begin
          case (state_reg)
            ST_IDLE: begin
              event_now  = 1'b1;
              state_next = ST_HELD;
              rcnt_next  = RPT_ONE;
            end
            ST_HELD: begin
              if ((REPEAT_EN != 0) && (rcnt_reg == RPT_DELAY_C)) begin
                event_now  = 1'b1;
                state_next = ST_REPEAT;
                rcnt_next  = RPT_ONE;
              end else if (rcnt_reg != RPT_SAT) begin
                rcnt_next = rcnt_reg + RPT_ONE;
              end
            end
            ST_REPEAT: begin
              if (rcnt_reg == RPT_PERIOD_C) begin
                event_now = 1'b1;
                rcnt_next = RPT_ONE;
              end else if (rcnt_reg != RPT_SAT) begin
                rcnt_next = rcnt_reg + RPT_ONE;
              end
            end
            default: begin
              state_next = ST_IDLE;
              rcnt_next  = '0;
            end
          endcase
        end
      end

      assign rpt_event[gi] = event_now;
    end
  endgenerate

  // Clear-key FSM state register (IDLE/HELD only, no repeat).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_state_reg <= ST_IDLE;
    end else begin
      clr_state_reg <= clr_state_next;
    end
  end

  // Clear key fires once per press edge.
  always_comb begin
    clr_state_next = clr_state_reg;
    clr_event      = 1'b0;
    if (!stable_level[2]) begin
      clr_state_next = ST_IDLE;
    end else if (clr_state_reg == ST_IDLE) begin
      clr_event      = 1'b1;
      clr_state_next = ST_HELD;
    end
  end

  // Arbitration uses the levels that appear on *_held alongside the pulse.
  always_comb begin
    inc_pulse_next = 1'b0;
    dec_pulse_next = 1'b0;
    clr_pulse_next = clr_event & ~clr_pulse_reg;
    if (stable_level[2]) begin
      inc_pulse_next = 1'b0;
      dec_pulse_next = 1'b0;
    end else if (stable_level[0] && stable_level[1]) begin
      inc_pulse_next = 1'b0;
      dec_pulse_next = 1'b0;
    end else begin
      inc_pulse_next = rpt_event[0] & ~inc_pulse_reg;
      dec_pulse_next = rpt_event[1] & ~dec_pulse_reg;
    end
  end

  // Output registers for pulses and held levels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inc_pulse_reg <= 1'b0;
      dec_pulse_reg <= 1'b0;
      clr_pulse_reg <= 1'b0;
      held_reg      <= 3'b000;
    end else begin
      inc_pulse_reg <= inc_pulse_next;
      dec_pulse_reg <= dec_pulse_next;
      clr_pulse_reg <= clr_pulse_next;
      held_reg      <= stable_level;
    end
  end

  assign inc_pulse = inc_pulse_reg;
  assign dec_pulse = dec_pulse_reg;
  assign clr_pulse = clr_pulse_reg;
  assign inc_held  = held_reg[0];
  assign dec_held  = held_reg[1];
  assign clr_held  = held_reg[2];

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner: scenario tasks plus randomized bouncy
// stimulus, checked against a timestamp-based reference model.
module tb_button_conditioner;

  localparam int D      = 4;
  localparam int DELAY  = 16;
  localparam int PERIOD = 8;
  localparam int NE     = 16384;

  logic clk;
  logic rst_n;
  logic btn_increment;
  logic btn_decrement;
  logic btn_reset;
  logic inc_pulse;
  logic dec_pulse;
  logic clr_pulse;
  logic inc_held;
  logic dec_held;
  logic clr_held;

  int n_checks = 0;
  int n_fails  = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_EN(1),
    .REPEAT_DELAY(DELAY),
    .REPEAT_PERIOD(PERIOD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_increment(btn_increment),
    .btn_decrement(btn_decrement),
    .btn_reset(btn_reset),
    .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse),
    .clr_pulse(clr_pulse),
    .inc_held(inc_held),
    .dec_held(dec_held),
    .clr_held(clr_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A key's level flips once the last D synchronized samples (raw value from
  // two edges earlier) all disagree with it and no flip happened in that
  // window. Press pulses land one edge after the flip; repeats land at
  // fixed offsets from acceptance while the level stays pressed.
  int         edge_n = 4;
  logic [2:0] rawh [NE];
  logic [2:0] m_stable = 3'b000;
  int         m_last_flip [3];
  int         m_accept [3];
  logic [5:0] exp_out = 6'b0;  // {inc_p, dec_p, clr_p, inc_h, dec_h, clr_h}
  logic [2:0] m_ev;
  logic       m_diff;
  int         m_off;

  always @(posedge clk) begin : ref_model
    edge_n = edge_n + 1;
    if (!rst_n) begin
      rawh[edge_n % NE]       = 3'b000;
      rawh[(edge_n - 1) % NE] = 3'b000;
      m_stable = 3'b000;
      for (int b = 0; b < 3; b++) begin
        m_last_flip[b] = edge_n;
        m_accept[b]    = -100000;
      end
      exp_out = 6'b0;
    end else begin
      rawh[edge_n % NE] = ~{btn_reset, btn_decrement, btn_increment};
      for (int b = 0; b < 2; b++) begin
        m_off   = edge_n - m_accept[b];
        m_ev[b] = m_stable[b] && ((m_off == 0) ||
                  ((m_off >= DELAY) && (((m_off - DELAY) % PERIOD) == 0)));
      end
      m_ev[2] = m_stable[2] && (edge_n == m_accept[2]);
      exp_out[5] = m_ev[0] && !m_stable[2] && !(m_stable[0] && m_stable[1]);
      exp_out[4] = m_ev[1] && !m_stable[2] && !(m_stable[0] && m_stable[1]);
      exp_out[3] = m_ev[2];
      exp_out[2] = m_stable[0];
      exp_out[1] = m_stable[1];
      exp_out[0] = m_stable[2];
      for (int b = 0; b < 3; b++) begin
        m_diff = (edge_n - D > m_last_flip[b]);
        for (int k = 1; k <= D; k++) begin
          if (rawh[(edge_n - k - 2) % NE][b] == m_stable[b]) m_diff = 1'b0;
        end
        if (m_diff) begin
          m_stable[b]    = ~m_stable[b];
          m_last_flip[b] = edge_n;
          if (m_stable[b]) m_accept[b] = edge_n + 1;
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [5:0] got;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = {inc_pulse, dec_pulse, clr_pulse, inc_held, dec_held, clr_held};
      n_checks++;
      if (got !== 6'b0) begin
        n_fails++;
        $display("FAIL reset_value edge %0d: got %b required %b", edge_n, got, 6'b0);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      got = {inc_pulse, dec_pulse, clr_pulse, inc_held, dec_held, clr_held};
      n_checks++;
      if (got !== 6'b0) begin
        n_fails++;
        $display("FAIL reset_idle edge %0d: got %b required %b", edge_n, got, 6'b0);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [5:0] got;
    logic       exp_p;
    int         pulses = 0;
    btn_increment = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      got = {inc_pulse, dec_pulse, clr_pulse, inc_held, dec_held, clr_held};
      n_checks++;
      if (got !== exp_out) begin
        n_fails++;
        $display("FAIL clean_model edge %0d: got %b required %b", edge_n, got, exp_out);
      end
      exp_p = (i == D + 3);
      n_checks++;
      if (inc_pulse !== exp_p || dec_pulse !== 1'b0 || clr_pulse !== 1'b0) begin
        n_fails++;
        $display("FAIL clean_pulse_timing step %0d: got inc=%b dec=%b clr=%b required inc=%b dec=0 clr=0",
                 i, inc_pulse, dec_pulse, clr_pulse, exp_p);
      end
      exp_p = (i >= D + 3);
      n_checks++;
      if (inc_held !== exp_p) begin
        n_fails++;
        $display("FAIL clean_held step %0d: got %b required %b", i, inc_held, exp_p);
      end
      if (inc_pulse === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 1) begin
      n_fails++;
      $display("FAIL clean_pulse_count: got %0d required 1", pulses);
    end
    btn_increment = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      got = {inc_pulse, dec_pulse, clr_pulse, inc_held, dec_held, clr_held};
      n_checks++;
      if (got !== exp_out) begin
        n_fails++;
        $display("FAIL clean_release edge %0d: got %b required %b", edge_n, got, exp_out);
      end
    end
  endtask

  task automatic test_bounce();
    logic [5:0] got;
    int lens [10];
    logic lvls [10];
    lens = '{2, 1, 3, 10, 0, 0, 0, 0, 0, 0};
    lvls = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    // Random glitches, all shorter than the debounce window.
    for (int s = 4; s < 10; s += 2) begin
      lens[s]     = $urandom_range(1, D - 1);
      lvls[s]     = 1'b0;
      lens[s + 1] = $urandom_range(1, 4);
      lvls[s + 1] = 1'b1;
    end
    lens[9] = 12;
    for (int s = 0; s < 10; s++) begin
      btn_decrement = lvls[s];
      for (int c = 0; c < lens[s]; c++) begin
        @(negedge clk);
        got = {inc_pulse, dec_pulse, clr_pulse, inc_held, dec_held, clr_held};
        n_checks++;
        if (got !== exp_out) begin
          n_fails++;
          $display("FAIL bounce_model edge %0d: got %b required %b", edge_n, got, exp_out);
        end
        n_checks++;
        if (dec_pulse !== 1'b0 || dec_held !== 1'b0) begin
          n_fails++;
          $display("FAIL bounce_reject edge %0d: got pulse=%b held=%b required 0/0",
                   edge_n, dec_pulse, dec_held);
        end
      end
    end
  endtask

  task automatic test_repeat();
    logic [5:0] got;
    logic found = 1'b0;
    int   offs[$];
    btn_increment = 1'b0;
    for (int w = 0; w < 30 && !found; w++) begin
      @(negedge clk);
      got = {inc_pulse, dec_pulse, clr_pulse, inc_held, dec_held, clr_held};
      n_checks++;
      if (got !== exp_out) begin
        n_fails++;
        $display("FAIL repeat_model edge %0d: got %b required %b", edge_n, got, exp_out);
      end
      if (inc_pulse === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fails++;
      $display("FAIL repeat_accept_timeout: got no inc_pulse in 30 cycles required one");
    end
    for (int t = 1; t <= 64; t++) begin
      @(negedge clk);
      got = {inc_pulse, dec_pulse, clr_pulse, inc_held, dec_held, clr_held};
      n_checks++;
      if (got !== exp_out) begin
        n_fails++;
        $display("FAIL repeat_model edge %0d: got %b required %b", edge_n, got, exp_out);
      end
      if (inc_pulse === 1'b1) offs.push_back(t);
      if (t == 44) btn_increment = 1'b1;
    end
    n_checks++;
    if (offs.size() != 5) begin
      n_fails++;
      $display("FAIL repeat_count: got %0d repeat pulses required 5", offs.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_checks++;
        if (offs[k] != DELAY + k * PERIOD) begin
          n_fails++;
          $display("FAIL repeat_offset %0d: got +%0d required +%0d", k, offs[k], DELAY + k * PERIOD);
        end
      end
    end
  endtask

  task automatic test_conflict();
    logic [5:0] got;
    int clr_count = 0;
    btn_increment = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      got = {inc_pulse, dec_pulse, clr_pulse, inc_held, dec_held, clr_held};
      n_checks++;
      if (got !== exp_out) begin
        n_fails++;
        $display("FAIL conflict_model edge %0d: got %b required %b", edge_n, got, exp_out);
      end
    end
    btn_decrement = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      got = {inc_pulse, dec_pulse, clr_pulse, inc_held, dec_held, clr_held};
      n_checks++;
      if (got !== exp_out || inc_pulse !== 1'b0 || dec_pulse !== 1'b0) begin
        n_fails++;
        $display("FAIL conflict_incdec edge %0d: got %b required %b with no inc/dec pulse",
                 edge_n, got, exp_out);
      end
    end
    btn_reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      got = {inc_pulse, dec_pulse, clr_pulse, inc_held, dec_held, clr_held};
      n_checks++;
      if (got !== exp_out || inc_pulse !== 1'b0 || dec_pulse !== 1'b0) begin
        n_fails++;
        $display("FAIL conflict_clear edge %0d: got %b required %b with no inc/dec pulse",
                 edge_n, got, exp_out);
      end
      if (clr_pulse === 1'b1) clr_count++;
    end
    n_checks++;
    if (clr_count != 1) begin
      n_fails++;
      $display("FAIL conflict_clr_count: got %0d required 1", clr_count);
    end
    // Drop decrement while clear is still held: inc stays suppressed.
    btn_decrement = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 12) begin
        btn_increment = 1'b1;
        btn_reset     = 1'b1;
      end
      @(negedge clk);
      got = {inc_pulse, dec_pulse, clr_pulse, inc_held, dec_held, clr_held};
      n_checks++;
      if (got !== exp_out || inc_pulse !== 1'b0) begin
        n_fails++;
        $display("FAIL conflict_release edge %0d: got %b required %b", edge_n, got, exp_out);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [5:0] got;
    logic exp_p;
    int   pulses = 0;
    btn_increment = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      got = {inc_pulse, dec_pulse, clr_pulse, inc_held, dec_held, clr_held};
      n_checks++;
      if (got !== exp_out) begin
        n_fails++;
        $display("FAIL midreset_model edge %0d: got %b required %b", edge_n, got, exp_out);
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    got = {inc_pulse, dec_pulse, clr_pulse, inc_held, dec_held, clr_held};
    n_checks++;
    if (got !== 6'b0) begin
      n_fails++;
      $display("FAIL midreset_clear edge %0d: got %b required %b", edge_n, got, 6'b0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      got = {inc_pulse, dec_pulse, clr_pulse, inc_held, dec_held, clr_held};
      exp_p = (i == D + 3);
      n_checks++;
      if (got !== exp_out || inc_pulse !== exp_p) begin
        n_fails++;
        $display("FAIL midreset_fresh step %0d: got %b required %b (inc_pulse %b)",
                 i, got, exp_out, exp_p);
      end
      if (inc_pulse === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 1) begin
      n_fails++;
      $display("FAIL midreset_pulse_count: got %0d required 1", pulses);
    end
    btn_increment = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      got = {inc_pulse, dec_pulse, clr_pulse, inc_held, dec_held, clr_held};
      n_checks++;
      if (got !== exp_out) begin
        n_fails++;
        $display("FAIL midreset_release edge %0d: got %b required %b", edge_n, got, exp_out);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] got;
    logic [2:0] intent = 3'b111;
    int bounce [3] = '{0, 0, 0};
    logic [2:0] drive;
    for (int c = 0; c < 2500; c++) begin
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(0, 59) == 0) begin
          intent[b] = ~intent[b];
          bounce[b] = $urandom_range(0, 6);
        end
        drive[b] = intent[b];
        if (bounce[b] > 0) begin
          drive[b]  = intent[b] ^ 1'($urandom_range(0, 1));
          bounce[b] = bounce[b] - 1;
        end
      end
      btn_increment = drive[0];
      btn_decrement = drive[1];
      btn_reset     = drive[2];
      rst_n = ($urandom_range(0, 799) == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
      got = {inc_pulse, dec_pulse, clr_pulse, inc_held, dec_held, clr_held};
      n_checks++;
      if (got !== exp_out) begin
        n_fails++;
        $display("FAIL random_model edge %0d: got %b required %b", edge_n, got, exp_out);
      end
      n_checks++;
      if (inc_pulse === 1'b1 && dec_pulse === 1'b1) begin
        n_fails++;
        $display("FAIL random_exclusive edge %0d: got inc=1 dec=1 required not both", edge_n);
      end
    end
    rst_n         = 1'b1;
    btn_increment = 1'b1;
    btn_decrement = 1'b1;
    btn_reset     = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      got = {inc_pulse, dec_pulse, clr_pulse, inc_held, dec_held, clr_held};
      n_checks++;
      if (got !== exp_out) begin
        n_fails++;
        $display("FAIL random_settle edge %0d: got %b required %b", edge_n, got, exp_out);
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    btn_increment = 1'b1;
    btn_decrement = 1'b1;
    btn_reset     = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat();
    test_conflict();
    test_reset_mid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Synchronous front end that turns the three raw, bouncy, active-low push-buttons (increment, decrement, reset) into clean single-cycle command pulses for the up/down counter. It sits between the board keys and the synchronous counter, replacing direct button-to-counter wiring. Each button is synchronized, debounced and edge-detected, with optional hold-to-repeat on increment and decrement. Inc/dec conflicts and reset priority are resolved here, so downstream logic sees at most one command per cycle.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required to accept a level change; legal range 1 to 2^16-1.
- REPEAT_EN, 1: 1 enables auto-repeat on increment and decrement; 0 disables it.
- REPEAT_DELAY, 16: cycles from the first press pulse to the first repeat pulse; must be at least 1.
- REPEAT_PERIOD, 8: cycles between subsequent repeat pulses; must be at least 1.

Ports (clock and reset first):
- clk, input, 1: the single clock for the block.
- rst_n, input, 1: synchronous, active-low reset, sampled on the rising edge of clk.
- btn_increment, input, 1: raw increment key, active-low (0 = pressed), asynchronous to clk.
- btn_decrement, input, 1: raw decrement key, active-low, asynchronous.
- btn_reset, input, 1: raw counter-clear key, active-low, asynchronous.
- inc_pulse, output, 1: one-cycle increment command.
- dec_pulse, output, 1: one-cycle decrement command.
- clr_pulse, output, 1: one-cycle clear command.
- inc_held, output, 1: debounced increment level (1 = pressed).
- dec_held, output, 1: debounced decrement level.
- clr_held, output, 1: debounced reset-key level.

## Operation

- **Synchronizer.** Each raw input passes through 2 flops. These flops reset to 1 (released).
- **Debouncer (per button).**
  - Holds a stable level (reset value: released) and a counter (reset value: 0).
  - Each cycle that the synchronized sample differs from the stable level, the counter increments.
  - Each cycle the sample matches the stable level, the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES, the stable level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the stable level.
- **Held outputs.** *_held equals the stable level, registered.
- **Per-button FSM** (inc and dec; the clear key uses only IDLE and HELD).
  - IDLE: stable level released. A press edge fires a press event and moves to HELD.
  - HELD: repeat counter runs. When it reaches REPEAT_DELAY (only if REPEAT_EN is 1), fire a repeat event and move to REPEAT. Release returns to IDLE.
  - REPEAT: fire an event every REPEAT_PERIOD cycles. Release returns to IDLE.
  - Release in any state clears the repeat counter; no pulse is generated on release.
- **Arbitration.** Applied to the events each cycle, in order:
  - clr_held = 1: inc_pulse and dec_pulse are forced to 0. The inc/dec FSMs keep running, but their events are discarded.
  - inc_held and dec_held both 1: both inc/dec events are discarded.
  - Otherwise, each event drives its pulse.
  - clr_pulse fires only on the clear-key press event; the clear key has no repeat.
- **Pulse rules.**
  - All pulses are registered, 1 cycle wide, and never back-to-back for the same button.
  - inc_pulse and dec_pulse are never high in the same cycle.
- **Reset behaviour.**
  - rst_n = 0 at any clock edge: all outputs go to 0 on that edge, all FSMs go to IDLE, and all counters go to 0.
  - A key still held when rst_n releases must first be debounced, then produces one press pulse.

## Timing

- **Press latency.**
  - Edge 0 is the first rising edge at which a raw input is sampled low.
  - With the input held low, the pulse is high during the cycle after edge DEBOUNCE_CYCLES+3 (2 sync stages, DEBOUNCE_CYCLES debounce, 1 output register).
  - With the default of 4, the pulse appears after edge 7.
- **Held latency.** *_held rises on the same edge as the press pulse and falls DEBOUNCE_CYCLES+3 edges after the raw input returns high. It falls with no pulse.
- **Repeat timing.**
  - The first repeat pulse occurs REPEAT_DELAY cycles after the press pulse.
  - Later repeat pulses occur every REPEAT_PERIOD cycles, as long as the key stays stable-pressed.
- **Conflict timing.** Suppression uses *_held values from the same cycle as the event, so there is no extra latency.
- **Repeat counter.** The counter saturates; it never wraps.
- **Counter width.** The debounce counter is wide enough for DEBOUNCE_CYCLES, and the repeat counter for max(REPEAT_DELAY, REPEAT_PERIOD).

## Test plan

1. **Reset values.** Drive rst_n = 0 for 3 edges with all keys high. Then release reset and idle 20 cycles. Required: all six outputs are 0 throughout.
2. **Clean press.** With DEBOUNCE_CYCLES = 4, drive btn_increment low at edge 0 and hold it for 12 cycles (REPEAT_EN = 0). Required: exactly one inc_pulse, in the cycle after edge 7; inc_held = 1 from that edge; dec_pulse and clr_pulse stay 0.
3. **Bounce rejection.** Toggle btn_decrement low for 2 cycles, high for 1, low for 3, then high for 10. Required: dec_pulse and dec_held remain 0.
4. **Auto-repeat.** With REPEAT_EN = 1, DELAY = 16 and PERIOD = 8, hold btn_increment low for 50 cycles after acceptance. Required: inc_pulse at acceptance, then at +16, +24, +32, +40 and +48 (6 pulses); no pulse after release.
5. **Conflict and priority.**
   - Hold increment, then press decrement so it debounces while increment is held. Required: no further inc_pulse or dec_pulse while both *_held are 1.
   - Then press btn_reset. Required: one clr_pulse, and inc/dec stay suppressed while clr_held = 1.
6. **Reset mid-hold.** With increment in REPEAT, pulse rst_n low for 1 edge while the key is still held. Required: outputs go to 0 on that edge, and one fresh inc_pulse occurs 7 edges after reset releases.
